// File: rtl/lsu_byte_ram_ctrl_if.sv
// Bundles the CPU request/response handshake and both byte ports of the data RAM.
// Modports:
//   master - the load/store controller: takes requests, drives RAM ports, returns responses
//   slave  - the surrounding environment: memory-stage request source plus the RAM itself
// Signals:
//   req_valid/req_ready, req_we, req_size, req_unsigned, req_addr, req_wdata
//   resp_valid, resp_rdata
//   mem_we1/2, mem_addr1/2, mem_wdata1/2, mem_rdata1/2
interface lsu_byte_ram_ctrl_if #(
  parameter int unsigned ADDR_W = 32
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;

  logic              mem_we1;
  logic              mem_we2;
  logic [ADDR_W-1:0] mem_addr1;
  logic [ADDR_W-1:0] mem_addr2;
  logic [7:0]        mem_wdata1;
  logic [7:0]        mem_wdata2;
  logic [7:0]        mem_rdata1;
  logic [7:0]        mem_rdata2;

  modport master (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata,
    output mem_we1, mem_we2, mem_addr1, mem_addr2, mem_wdata1, mem_wdata2,
    input  mem_rdata1, mem_rdata2
  );

  modport slave (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata,
    input  mem_we1, mem_we2, mem_addr1, mem_addr2, mem_wdata1, mem_wdata2,
    output mem_rdata1, mem_rdata2
  );
endinterface

// File: rtl/lsu_byte_ram_ctrl.sv
// Load/store controller for a dual-port byte-wide data RAM. Takes one byte/half/word
// request at a time, splits it into little-endian byte accesses (two per cycle, ports
// 1 and 2), and reassembles load data with sign/zero extension.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - asynchronous active-low reset; drops any request in flight
//   bus    - lsu_byte_ram_ctrl_if.master: CPU handshake, response, RAM byte ports
module lsu_byte_ram_ctrl #(
  parameter int unsigned ADDR_W = 32
) (
  input logic                       clk,
  input logic                       rst_n,
  lsu_byte_ram_ctrl_if.master       bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC0 = 2'd1,
    ACC1 = 2'd2,
    CAP  = 2'd3
  } state_e;

  typedef struct packed {
    logic              we;
    logic [1:0]        size;
    logic              uns;
    logic [ADDR_W-1:0] addr;
  } req_t;

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic [31:0]       data_q, data_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       resp_rdata_q, resp_rdata_d;
  logic              we1_q, we1_d, we2_q, we2_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
  logic [7:0]        wdata1_q, wdata1_d, wdata2_q, wdata2_d;
  logic [31:0]       raw;

  // Sign/zero extension of the assembled little-endian load value.
  function automatic logic [31:0] extend(input logic [1:0] size, input logic uns,
                                         input logic [31:0] val);
    logic [31:0] r;
    if (size[1])            r = val;
    else if (size == 2'd1)  r = {(uns ? 16'h0 : {16{val[15]}}), val[15:0]};
    else                    r = {(uns ? 24'h0 : {24{val[7]}}), val[7:0]};
    return r;
  endfunction

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_q        <= '0;
      data_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      we1_q        <= 1'b0;
      we2_q        <= 1'b0;
      addr1_q      <= '0;
      addr2_q      <= '0;
      wdata1_q     <= '0;
      wdata2_q     <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      data_q       <= data_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      we1_q        <= we1_d;
      we2_q        <= we2_d;
      addr1_q      <= addr1_d;
      addr2_q      <= addr2_d;
      wdata1_q     <= wdata1_d;
      wdata2_q     <= wdata2_d;
    end
  end

  // Next state; RAM port values are computed for the state being entered so they are
  // presented straight from flops during that state.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    data_d       = data_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    we1_d        = 1'b0;
    we2_d        = 1'b0;
    addr1_d      = '0;
    addr2_d      = '0;
    wdata1_d     = '0;
    wdata2_d     = '0;
    raw          = '0;

    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          req_d.we   = bus.req_we;
          req_d.size = bus.req_size;
          req_d.uns  = bus.req_unsigned;
          req_d.addr = bus.req_addr;
          data_d     = bus.req_wdata;
          state_d    = ACC0;
          addr1_d    = bus.req_addr;
          addr2_d    = bus.req_addr + ADDR_W'(1);
          if (bus.req_we) begin
            we1_d    = 1'b1;
            we2_d    = (bus.req_size != 2'd0);
            wdata1_d = bus.req_wdata[7:0];
            wdata2_d = bus.req_wdata[15:8];
          end
        end
      end

      ACC0: begin
        if (req_q.size[1]) begin
          state_d = ACC1;
          addr1_d = req_q.addr + ADDR_W'(2);
          addr2_d = req_q.addr + ADDR_W'(3);
          if (req_q.we) begin
            we1_d    = 1'b1;
            we2_d    = 1'b1;
            wdata1_d = data_q[23:16];
            wdata2_d = data_q[31:24];
          end
        end else if (!req_q.we) begin
          state_d = CAP;
          addr1_d = addr1_q;
          addr2_d = addr2_q;
        end else begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
        end
      end

      ACC1: begin
        if (req_q.we) begin
          state_d      = IDLE;
          resp_valid_d = 1'b1;
          resp_rdata_d = '0;
        end else begin
          // RAM now returns the ACC0 bytes (0 and 1).
          state_d      = CAP;
          addr1_d      = addr1_q;
          addr2_d      = addr2_q;
          data_d[15:0] = {bus.mem_rdata2, bus.mem_rdata1};
        end
      end

      CAP: begin
        if (req_q.size[1]) raw = {bus.mem_rdata2, bus.mem_rdata1, data_q[15:0]};
        else               raw = {16'h0, bus.mem_rdata2, bus.mem_rdata1};
        data_d       = raw;
        resp_rdata_d = extend(req_q.size, req_q.uns, raw);
        resp_valid_d = 1'b1;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_we1    = we1_q;
  assign bus.mem_we2    = we2_q;
  assign bus.mem_addr1  = addr1_q;
  assign bus.mem_addr2  = addr2_q;
  assign bus.mem_wdata1 = wdata1_q;
  assign bus.mem_wdata2 = wdata2_q;

endmodule

// File: doc/lsu_byte_ram_ctrl.md
Name: lsu_byte_ram_ctrl

Overview:
- Load/store initiator for the dual-port byte-wide data RAM: the CPU-side master that drives that RAM's two byte ports.
- Accepts one byte/half/word load or store from the CPU memory stage.
- Splits it into little-endian byte accesses over both ports (2 bytes per cycle) and reassembles load data with sign/zero extension.
- Sits between the execute/memory stage and the data RAM; RAM read data is registered, 1-cycle latency.

Parameters:
ADDR_W, 32, width of CPU request address and RAM port addresses; all offset arithmetic wraps modulo 2^ADDR_W

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  asynchronous, active-low reset
req_valid  input  1  CPU request valid
req_ready  output  1  block can accept request
req_we  input  1  1=store, 0=load
req_size  input  2  0=byte, 1=half, 2=word, 3=treated as word
req_unsigned  input  1  zero-extend load (ignored for word/stores)
req_addr  input  ADDR_W  byte address, any alignment
req_wdata  input  32  store data, byte k = bits [8k+7:8k]
resp_valid  output  1  one-cycle completion pulse
resp_rdata  output  32  extended load data; 0 for stores
mem_we1, mem_we2  output  1 each  byte write enables, port 1/2
mem_addr1, mem_addr2  output  ADDR_W each  byte addresses, port 1/2
mem_wdata1, mem_wdata2  output  8 each  write bytes
mem_rdata1, mem_rdata2  input  8 each  registered read bytes (valid the cycle after address)

Behaviour:
- Reset (async, rst_n=0): state IDLE; latched addr/size/data cleared; resp_valid=0, resp_rdata=0; mem_we1/2=0, mem_addr1/2=0, mem_wdata1/2=0. In-flight request dropped, no response. Bytes already written stay written; a word store cut after ACC0 leaves bytes 0,1 written.
- States: IDLE, ACC0, ACC1, CAP.
- req_ready = (state==IDLE). Accept on rising edge with req_valid&&req_ready: latch addr, size, we, unsigned, wdata; go to ACC0. req_valid while busy is ignored; no queueing.
- ACC0: mem_addr1=A, mem_addr2=A+1.
  - Store: mem_we1=1, mem_wdata1=wdata[7:0]; mem_we2=1 only for half/word, mem_wdata2=wdata[15:8].
  - Next: word→ACC1; B/H load→CAP; B/H store→IDLE with resp_valid<=1.
- ACC1 (word only): mem_addr1=A+2, mem_addr2=A+3; store writes wdata[23:16], wdata[31:24] on both ports.
  - Load: capture mem_rdata1/2 into bytes 0/1 at end of cycle, then CAP.
  - Store: IDLE with resp_valid<=1.
- CAP (loads): no writes.
  - Word: capture mem_rdata1/2 into bytes 2/3.
  - B/H: capture bytes 0/1 from mem_rdata1/2.
  - Then IDLE with resp_valid<=1 and resp_rdata<=extended result.
- Extension:
  - Byte: bits[31:8] = req_unsigned ? 0 : bit7.
  - Half: bits[31:16] = req_unsigned ? 0 : bit15.
  - Word: no extension.
- mem_we1/2 are 0 in IDLE and CAP. Port addresses and wdata are 0 in IDLE and hold the last ACC value in CAP.
- resp_valid is a single-cycle registered pulse; it is 0 in every other cycle. resp_rdata holds until the next completion.
- Latency, counted as the number of cycles after the accept cycle until resp_valid is high:
  - B/H store: 2
  - word store: 3
  - B/H load: 3
  - word load: 4
- Back-to-back: resp_valid coincides with IDLE, so a new request is accepted in the resp_valid cycle.
- Misaligned accesses are legal and need no extra cycles. Addresses wrap modulo 2^ADDR_W, e.g. A=0xFFFFFFFF gives A+1=0x00000000.
- Port 1 and port 2 addresses never coincide within a cycle, so there is no same-cycle write conflict.

Test Plan:
- Store word 0xDEADBEEF @0x100, then load word @0x100 → RAM bytes 0x100..0x103 = EF,BE,AD,DE; resp_rdata=0xDEADBEEF; resp_valid 3 and 4 cycles after the respective accepts.
- RAM[0x20]=0x80: load byte signed → 0xFFFFFF80; load byte unsigned → 0x00000080. RAM[0x21..0x22]=0x34,0x92: half signed @0x21 → 0xFFFF9234.
- Store half 0xA55A @0x1001 → only 0x1001=5A, 0x1002=A5 written; mem_we2=0 on a byte store to 0x1003 and 0x1004 unchanged.
- Load-word request held during resp_valid of a prior store → accepted that cycle; req_valid during ACC0/ACC1/CAP → req_ready=0, no extra RAM activity.
- Assert rst_n=0 during ACC1 of word store 0x11223344 @0x200 → only 0x200=44, 0x201=33 written; resp_valid never asserts; all outputs 0 immediately.
- Word load @0xFFFFFFFE → port addresses FFFFFFFE, FFFFFFFF, then 00000000, 00000001; data assembled little-endian.
